// File: rtl/draw_pkg.sv
// Shared types for the line generator: controller states, direction codes and
// the mapping from a direction code to its per-step x/y increment.
package draw_pkg;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  localparam logic [2:0] DIR_XP = 3'd0;
  localparam logic [2:0] DIR_XN = 3'd1;
  localparam logic [2:0] DIR_YP = 3'd2;
  localparam logic [2:0] DIR_YN = 3'd3;
  localparam logic [2:0] DIR_PP = 3'd4;
  localparam logic [2:0] DIR_PN = 3'd5;
  localparam logic [2:0] DIR_NP = 3'd6;
  localparam logic [2:0] DIR_NN = 3'd7;

  localparam logic signed [1:0] STEP_POS  = 2'sb01;
  localparam logic signed [1:0] STEP_NEG  = 2'sb11;
  localparam logic signed [1:0] STEP_ZERO = 2'sb00;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  function automatic delta_t dir_to_delta(input logic [2:0] d);
    delta_t r;
    r.dx = STEP_ZERO;
    r.dy = STEP_ZERO;
    case (d)
      DIR_XP: r.dx = STEP_POS;
      DIR_XN: r.dx = STEP_NEG;
      DIR_YP: r.dy = STEP_POS;
      DIR_YN: r.dy = STEP_NEG;
      DIR_PP: begin r.dx = STEP_POS; r.dy = STEP_POS; end
      DIR_PN: begin r.dx = STEP_POS; r.dy = STEP_NEG; end
      DIR_NP: begin r.dx = STEP_NEG; r.dy = STEP_POS; end
      DIR_NN: begin r.dx = STEP_NEG; r.dy = STEP_NEG; end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/point_ram.sv
// Simple dual-port point buffer: one write port, one synchronous read port.
module point_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/draw_line_gen.sv
// Line point generator: steps from a start point in one of 8 directions,
// one point per clock, into a buffer readable through a gated read port.
module draw_line_gen
  import draw_pkg::*;
#(
  parameter int COORD_W = 32,
  parameter int MAX_LEN = 32,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wea,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [2:0]         dir,
  input  logic [IDX_W:0]     len,
  input  logic [IDX_W-1:0]   index_rd,
  output logic [COORD_W-1:0] line_x,
  output logic [COORD_W-1:0] line_y,
  output logic [IDX_W:0]     count,
  output logic               busy,
  output logic               finish,
  output logic               err
);

  localparam int CNT_W = IDX_W + 1;

  state_t                     state;
  delta_t                     delta_in;
  logic signed [1:0]          dx_q, dy_q;
  logic signed [COORD_W-1:0]  cur_x_p0, cur_y_p0;
  logic [CNT_W-1:0]           len_q;
  logic                       len_ok;
  logic                       accept;
  logic                       rd_ok_p1;
  logic [2*COORD_W-1:0]       rd_data_p1;

  assign delta_in = dir_to_delta(dir);
  assign len_ok   = (len != '0) && (len <= CNT_W'(MAX_LEN));
  assign accept   = wea && (state != GEN);

  // Stage p0: latch the request, then advance the current point each GEN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_x_p0 <= x;
      cur_y_p0 <= y;
      dx_q     <= delta_in.dx;
      dy_q     <= delta_in.dy;
      len_q    <= len;
    end else if (state == GEN) begin
      cur_x_p0 <= cur_x_p0 + COORD_W'(dx_q);
      cur_y_p0 <= cur_y_p0 + COORD_W'(dy_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      err      <= 1'b0;
      rd_ok_p1 <= 1'b0;
    end else begin
      // Gate against the pre-edge count so a same-edge write reads as 0.
      rd_ok_p1 <= ({1'b0, index_rd} < count);
      case (state)
        IDLE, DONE: begin
          if (wea) begin
            count  <= '0;
            finish <= 1'b0;
            err    <= 1'b0;
            if (len_ok) begin
              state <= GEN;
              busy  <= 1'b1;
            end else begin
              state  <= DONE;
              finish <= 1'b1;
              err    <= 1'b1;
            end
          end
        end
        GEN: begin
          count <= count + CNT_W'(1);
          if (count + CNT_W'(1) == len_q) begin
            state  <= DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  point_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (IDX_W),
    .DATA_W (2*COORD_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (state == GEN),
    .wr_addr (count[IDX_W-1:0]),
    .wr_data ({cur_x_p0, cur_y_p0}),
    .rd_addr (index_rd),
    .rd_data (rd_data_p1)
  );

  // Stage p1: registered read data, zeroed when the index was not yet written
  assign line_x = rd_ok_p1 ? rd_data_p1[2*COORD_W-1:COORD_W] : '0;
  assign line_y = rd_ok_p1 ? rd_data_p1[COORD_W-1:0]         : '0;

endmodule

// File: tb/tb_draw_line_gen.sv
// Scoreboard bench for draw_line_gen with an arithmetic point model.
module tb_draw_line_gen;

  localparam int CW = 8;
  localparam int ML = 32;
  localparam int IW = $clog2(ML);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wea = 1'b0;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic [2:0]    dir = '0;
  logic [IW:0]   len = '0;
  logic [IW-1:0] index_rd = '0;
  logic [CW-1:0] line_x, line_y;
  logic [IW:0]   count;
  logic          busy, finish, err;

  draw_line_gen #(.COORD_W(CW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .wea(wea), .x(x), .y(y), .dir(dir), .len(len),
    .index_rd(index_rd), .line_x(line_x), .line_y(line_y), .count(count),
    .busy(busy), .finish(finish), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;
  chk_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  int dxs[8] = '{1, -1, 0, 0, 1, 1, -1, -1};
  int dys[8] = '{0, 0, 1, -1, 1, -1, 1, -1};
  int m_x = 0, m_y = 0, m_dir = 0, m_cnt = 0;

  function automatic logic [15:0] pt(input int sx, input int sy, input int d, input int k);
    int px, py;
    px = sx + k * dxs[d];
    py = sy + k * dys[d];
    px = ((px % 256) + 256) % 256;
    py = ((py % 256) + 256) % 256;
    return 16'(px * 256 + py);
  endfunction

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      0: return {31'd0, busy};
      1: return {31'd0, finish};
      2: return {31'd0, err};
      3: return 32'(count);
      default: return {16'd0, line_x, line_y};
    endcase
  endfunction

  task automatic push(input int due, input int sig, input logic [31:0] e, input string n);
    chk_t c;
    c.due = due; c.sig = sig; c.exp = e; c.name = n;
    sb.push_back(c);
  endtask

  // Monitor: compare every entry whose cycle has come, away from the active edge.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          vectors++;
          act = actual(sb[i].sig);
          if (act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, cyc, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wea = 1'b0;
    tick();
    tick();
    push(cyc, 0, 0, "rst_busy");
    push(cyc, 1, 0, "rst_finish");
    push(cyc, 2, 0, "rst_err");
    push(cyc, 3, 0, "rst_count");
    push(cyc, 4, 0, "rst_line");
    rst_n = 1'b1;
    m_cnt = 0;
  endtask

  task automatic start(input int sx, input int sy, input int d, input int l,
                       input bit hold, input bit poke, input bit rd_gen);
    int c0;
    bit bad;
    bad = (l == 0) || (l > ML);
    x = CW'(sx); y = CW'(sy); dir = 3'(d); len = (IW+1)'(l); wea = 1'b1;
    c0 = cyc;
    push(c0 + 1, 1, 32'(bad), "finish_e0");
    push(c0 + 1, 2, 32'(bad), "err_e0");
    push(c0 + 1, 0, 32'(!bad), "busy_e0");
    push(c0 + 1, 3, 0, "count_e0");
    m_x = sx; m_y = sy; m_dir = d;
    tick();
    if (!hold) wea = 1'b0;
    if (bad) begin
      m_cnt = 0;
      return;
    end
    push(c0 + l, 0, 1, "busy_last");
    if (l >= 2) push(c0 + l, 1, 0, "finish_gen");
    push(c0 + 1 + l / 2, 3, 32'(l / 2), "count_mid");
    push(c0 + 1 + l, 0, 0, "busy_done");
    push(c0 + 1 + l, 1, 1, "finish_done");
    push(c0 + 1 + l, 2, 0, "err_done");
    push(c0 + 1 + l, 3, 32'(l), "count_done");
    for (int j = 0; j < l; j++) begin
      int idx;
      if (poke && j == 1) begin
        wea = 1'b1; x = CW'($urandom); y = CW'($urandom); dir = 3'($urandom); len = 1;
      end else if (poke && j == 2) begin
        wea = 1'b0;
      end
      if (rd_gen) begin
        idx = $urandom_range(0, ML - 1);
        index_rd = IW'(idx);
        push(cyc + 1, 4, (idx < j) ? 32'(pt(sx, sy, d, idx)) : 32'd0, "rd_gen");
      end
      tick();
    end
    m_cnt = l;
  endtask

  task automatic rd(input int idx);
    index_rd = IW'(idx);
    push(cyc + 1, 4, (idx < m_cnt) ? 32'(pt(m_x, m_y, m_dir, idx)) : 32'd0, "rd_model");
    tick();
  endtask

  task automatic rd_exp(input int idx, input logic [15:0] e, input string n);
    index_rd = IW'(idx);
    push(cyc + 1, 4, 32'(e), n);
    tick();
  endtask

  initial begin
    int l, r;
    do_reset();

    start(10, 10, 0, 5, 0, 0, 0);
    vectors++;
    if (count !== (IW+1)'(5)) begin
      miscompares++;
      $display("FAIL direct_count got=%0d want=5", count);
    end
    vectors++;
    if (finish !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_finish got=%0b want=1", finish);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_err got=%0b want=0", err);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_busy got=%0b want=0", busy);
    end
    rd_exp(0, 16'h0A0A, "xp_p0");
    rd_exp(1, 16'h0B0A, "xp_p1");
    rd_exp(2, 16'h0C0A, "xp_p2");
    rd_exp(3, 16'h0D0A, "xp_p3");
    rd_exp(4, 16'h0E0A, "xp_p4");

    start(10, 10, 1, 5, 0, 0, 0); rd_exp(4, 16'h060A, "xn_p4");
    start(10, 10, 2, 5, 0, 0, 0); rd_exp(4, 16'h0A0E, "yp_p4");
    start(10, 10, 3, 5, 0, 0, 1); rd_exp(4, 16'h0A06, "yn_p4");

    start(10, 10, 4, 3, 0, 0, 0); rd_exp(2, 16'h0C0C, "pp_p2");
    start(10, 10, 5, 3, 0, 0, 0); rd_exp(2, 16'h0C08, "pn_p2");
    start(10, 10, 6, 3, 0, 0, 0); rd_exp(2, 16'h080C, "np_p2");
    start(10, 10, 7, 3, 0, 0, 0); rd_exp(2, 16'h0808, "nn_p2");

    start(0, 0, 7, 2, 0, 0, 0);
    rd_exp(1, 16'hFFFF, "wrap_p1");
    rd_exp(5, 16'h0000, "wrap_gate");

    start(5, 5, 0, 0, 0, 0, 0);
    rd_exp(0, 16'h0000, "len0_read");
    start(5, 5, 0, ML + 1, 0, 0, 0);
    start(1, 2, 4, 3, 0, 0, 0);
    rd_exp(2, 16'h0304, "after_err_p2");

    start(20, 30, 2, 6, 0, 1, 0);
    rd_exp(5, 16'h1423, "poke_p5");

    // Reset asserted on the third GEN cycle.
    x = 1; y = 1; dir = 0; len = 8; wea = 1'b1;
    tick();
    wea = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    push(cyc + 1, 0, 0, "midrst_busy");
    push(cyc + 1, 3, 0, "midrst_count");
    push(cyc + 1, 1, 0, "midrst_finish");
    tick();
    rst_n = 1'b1;
    m_cnt = 0;
    push(cyc + 3, 3, 0, "midrst_stays");
    push(cyc + 3, 0, 0, "midrst_idle");
    tick();
    rd_exp(0, 16'h0000, "midrst_read");
    tick();

    start(3, 4, 4, 3, 1, 0, 0);
    start(7, 7, 5, 4, 0, 0, 0);
    rd_exp(3, 16'h0A04, "hold_p3");

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0) l = 0;
      else if (r == 1) l = ML + 1;
      else l = $urandom_range(1, ML);
      start($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), l,
            0, 0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) rd($urandom_range(0, ML - 1));
      rd(l > 0 && l <= ML ? l - 1 : 0);
    end

    tick();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0 && vectors > 0) $display("PASS");
    else $display("FAIL %0d miscompares", miscompares);
    $finish;
  end

endmodule
